// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared operation codes and FSM state encoding for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Operation select values carried on i_op
  localparam logic [2:0] PC_OP_HOLD    = 3'd0;
  localparam logic [2:0] PC_OP_INC     = 3'd1;
  localparam logic [2:0] PC_OP_LOAD_LO = 3'd2;
  localparam logic [2:0] PC_OP_LOAD_HI = 3'd3;
  localparam logic [2:0] PC_OP_LOAD    = 3'd4;
  localparam logic [2:0] PC_OP_BRANCH  = 3'd5;

  // Page-cross fixup FSM states
  typedef enum logic [0:0] {
    PC_ST_IDLE  = 1'b0,
    PC_ST_FIXUP = 1'b1
  } pc_state_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_low_lane.sv
`default_nettype none
// ============================================================================
// Module      : pc_low_lane
// Description : Combinational low-lane path of the program counter. Selects
//               the next pcl (hold, increment, ADL load, signed branch add)
//               and reports the lane carry and page-cross condition.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_low_lane
  import pc_pkg::*;
#(
  parameter int LO_W = 8
) (
  input  logic [2:0]      op_i,
  input  logic [LO_W-1:0] pcl_i,
  input  logic [LO_W-1:0] adl_i,
  input  logic [LO_W-1:0] offset_i,
  output logic [LO_W-1:0] pcl_next_o,
  output logic            carry_o,
  output logic            cross_o
);

  logic [LO_W:0] sum_inc;
  logic [LO_W:0] sum_br;

  // Unsigned adds; the branch page-cross is the carry corrected by the offset
  // sign, which equals bit LO_W of the sign-extended sum.
  assign sum_inc = {1'b0, pcl_i} + {{LO_W{1'b0}}, 1'b1};
  assign sum_br  = {1'b0, pcl_i} + {1'b0, offset_i};

  // Per-op selection of next pcl, carry and crossing
  always_comb begin
    pcl_next_o = pcl_i;
    carry_o    = 1'b0;
    cross_o    = 1'b0;
    case (op_i)
      PC_OP_INC: begin
        pcl_next_o = sum_inc[LO_W-1:0];
        carry_o    = sum_inc[LO_W];
      end
      PC_OP_LOAD_LO,
      PC_OP_LOAD: begin
        pcl_next_o = adl_i;
      end
      PC_OP_BRANCH: begin
        pcl_next_o = sum_br[LO_W-1:0];
        carry_o    = sum_br[LO_W];
        cross_o    = sum_br[LO_W] ^ offset_i[LO_W-1];
      end
      default: begin
        pcl_next_o = pcl_i;
      end
    endcase
  end

endmodule : pc_low_lane
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Parametrised program counter with split low/high lanes and a
//               two-cycle relative-branch page-cross fixup. The low lane is
//               updated on the branch cycle; the high lane is corrected on the
//               next enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int               PC_W        = 16,
  parameter int               LO_W        = 8,
  parameter logic [PC_W-1:0]  RESET_VALUE = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [2:0]           i_op,
  input  logic [LO_W-1:0]      i_adl,
  input  logic [PC_W-LO_W-1:0] i_adh,
  input  logic [LO_W-1:0]      i_offset,
  output logic [PC_W-1:0]      o_pc,
  output logic [LO_W-1:0]      o_pcl,
  output logic [PC_W-LO_W-1:0] o_pch,
  output logic                 o_pclc,
  output logic                 o_page_cross,
  output logic                 o_busy
);

  localparam int HI_W = PC_W - LO_W;

  pc_state_e         state_q, state_d;
  logic [LO_W-1:0]   pcl_q, pcl_d;
  logic [HI_W-1:0]   pch_q, pch_d;
  logic              dir_q, dir_d;   // 1 = fixup decrements pch

  logic [LO_W-1:0]   lane_pcl;
  logic              lane_carry;
  logic              lane_cross;

  pc_low_lane #(
    .LO_W (LO_W)
  ) u_low_lane (
    .op_i       (i_op),
    .pcl_i      (pcl_q),
    .adl_i      (i_adl),
    .offset_i   (i_offset),
    .pcl_next_o (lane_pcl),
    .carry_o    (lane_carry),
    .cross_o    (lane_cross)
  );

  // State and counter registers; reset wins over clock enable and FIXUP
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= PC_ST_IDLE;
      pcl_q   <= RESET_VALUE[LO_W-1:0];
      pch_q   <= RESET_VALUE[PC_W-1:LO_W];
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcl_q   <= pcl_d;
      pch_q   <= pch_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state, high-lane update and FSM transitions
  always_comb begin
    state_d = state_q;
    pcl_d   = pcl_q;
    pch_d   = pch_q;
    dir_d   = dir_q;
    if (i_ce) begin
      case (state_q)
        PC_ST_IDLE: begin
          pcl_d = lane_pcl;
          case (i_op)
            PC_OP_INC: begin
              if (lane_carry) begin
                pch_d = pch_q + {{(HI_W-1){1'b0}}, 1'b1};
              end
            end
            PC_OP_LOAD_HI,
            PC_OP_LOAD: begin
              pch_d = i_adh;
            end
            PC_OP_BRANCH: begin
              if (lane_cross) begin
                state_d = PC_ST_FIXUP;
                dir_d   = i_offset[LO_W-1];
              end
            end
            default: begin
              pch_d = pch_q;
            end
          endcase
        end
        PC_ST_FIXUP: begin
          // pcl already holds the branch target offset; only the page moves
          if (dir_q) begin
            pch_d = pch_q - {{(HI_W-1){1'b0}}, 1'b1};
          end else begin
            pch_d = pch_q + {{(HI_W-1){1'b0}}, 1'b1};
          end
          state_d = PC_ST_IDLE;
        end
        default: begin
          state_d = PC_ST_IDLE;
        end
      endcase
    end
  end

  assign o_pc         = {pch_q, pcl_q};
  assign o_pcl        = pcl_q;
  assign o_pch        = pch_q;
  assign o_pclc       = lane_carry;
  assign o_page_cross = (state_q == PC_ST_FIXUP);
  assign o_busy       = (state_q == PC_ST_FIXUP);

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed, table-driven self-checking bench for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  localparam logic [2:0] OP_HOLD    = 3'd0;
  localparam logic [2:0] OP_INC     = 3'd1;
  localparam logic [2:0] OP_LOAD_LO = 3'd2;
  localparam logic [2:0] OP_LOAD_HI = 3'd3;
  localparam logic [2:0] OP_LOAD    = 3'd4;
  localparam logic [2:0] OP_BRANCH  = 3'd5;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [2:0]  op;
  logic [7:0]  adl;
  logic [7:0]  adh;
  logic [7:0]  offset;
  logic [15:0] pc;
  logic [7:0]  pcl;
  logic [7:0]  pch;
  logic        pclc;
  logic        page_cross;
  logic        busy;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [2:0]  op;
    logic [7:0]  adl;
    logic [7:0]  adh;
    logic [7:0]  off;
    logic [15:0] pc;
    logic        busy;
    logic        pclc;
  } vec_t;

  vec_t vecs[$];

  pc_unit #(
    .PC_W        (16),
    .LO_W        (8),
    .RESET_VALUE (16'h0000)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_ce         (ce),
    .i_op         (op),
    .i_adl        (adl),
    .i_adh        (adh),
    .i_offset     (offset),
    .o_pc         (pc),
    .o_pcl        (pcl),
    .o_pch        (pch),
    .o_pclc       (pclc),
    .o_page_cross (page_cross),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic c, input logic [2:0] o,
                              input logic [7:0] l, input logic [7:0] h, input logic [7:0] f,
                              input logic [15:0] p, input logic b, input logic cy);
    vec_t v;
    v.rst = r; v.ce = c; v.op = o; v.adl = l; v.adh = h; v.off = f;
    v.pc = p; v.busy = b; v.pclc = cy;
    return v;
  endfunction

  // Drive one cycle, check carry before the edge and registered state after it
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; ce = v.ce; op = v.op; adl = v.adl; adh = v.adh; offset = v.off;
    #1;
    n_vec++;
    if (pclc !== v.pclc) begin
      n_err++;
      $display("FAIL %s pclc: got %b want %b", name, pclc, v.pclc);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (pc !== v.pc) begin
      n_err++;
      $display("FAIL %s pc: got %h want %h", name, pc, v.pc);
    end
    if (busy !== v.busy) begin
      n_err++;
      $display("FAIL %s busy: got %b want %b", name, busy, v.busy);
    end
    if (page_cross !== v.busy) begin
      n_err++;
      $display("FAIL %s page_cross: got %b want %b", name, page_cross, v.busy);
    end
    if ({pch, pcl} !== v.pc) begin
      n_err++;
      $display("FAIL %s pch/pcl: got %h/%h want %h", name, pch, pcl, v.pc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0; ce = 1'b0; op = OP_HOLD; adl = '0; adh = '0; offset = '0;

    //               rst   ce    op          adl    adh    off    pc        busy  pclc
    vecs.push_back(mk(1'b1, 1'b0, OP_HOLD,    8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'hFF, 8'h12, 8'h00, 16'h12FF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_INC,     8'h00, 8'h00, 8'h00, 16'h1300, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, OP_INC,     8'h00, 8'h00, 8'h00, 16'h1301, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'hFF, 8'hFF, 8'h00, 16'hFFFF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_INC,     8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD_HI, 8'h77, 8'h12, 8'h00, 16'h1200, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD_LO, 8'h34, 8'h99, 8'h00, 16'h1234, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD_HI, 8'h55, 8'hAB, 8'h00, 16'hAB34, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'h78, 8'h56, 8'h00, 16'h5678, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, OP_INC,     8'h00, 8'h00, 8'h00, 16'h5678, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 3'd6,       8'h11, 8'h22, 8'h00, 16'h5678, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 3'd7,       8'h11, 8'h22, 8'h00, 16'h5678, 1'b0, 1'b0));
    // forward branch crossing a page
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'hF0, 8'h10, 8'h00, 16'h10F0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_BRANCH,  8'h00, 8'h00, 8'h20, 16'h1010, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, OP_HOLD,    8'h00, 8'h00, 8'h00, 16'h1110, 1'b0, 1'b0));
    // forward branch within the page
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'hF0, 8'h10, 8'h00, 16'h10F0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_BRANCH,  8'h00, 8'h00, 8'h05, 16'h10F5, 1'b0, 1'b0));
    // backward branch crossing a page
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'h05, 8'h10, 8'h00, 16'h1005, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_BRANCH,  8'h00, 8'h00, 8'hF0, 16'h10F5, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_HOLD,    8'h00, 8'h00, 8'h00, 16'h0FF5, 1'b0, 1'b0));
    // backward branch wrapping the high lane
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'h05, 8'h00, 8'h00, 16'h0005, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_BRANCH,  8'h00, 8'h00, 8'hF0, 16'h00F5, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_HOLD,    8'h00, 8'h00, 8'h00, 16'hFFF5, 1'b0, 1'b0));
    // backward branch within the page, then zero offset
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'h20, 8'h10, 8'h00, 16'h1020, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_BRANCH,  8'h00, 8'h00, 8'hF0, 16'h1010, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, OP_BRANCH,  8'h00, 8'h00, 8'h00, 16'h1010, 1'b0, 1'b0));
    // forward branch crossing the top page wraps high lane to 00
    vecs.push_back(mk(1'b0, 1'b1, OP_LOAD,    8'hFE, 8'hFF, 8'h00, 16'hFFFE, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, OP_BRANCH,  8'h00, 8'h00, 8'h03, 16'hFF01, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, OP_HOLD,    8'h00, 8'h00, 8'h00, 16'h0001, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Stall in FIXUP for three cycles; a LOAD presented meanwhile is ignored
    step(mk(1'b0, 1'b1, OP_LOAD,   8'hF0, 8'h10, 8'h00, 16'h10F0, 1'b0, 1'b0), "stall_load");
    step(mk(1'b0, 1'b1, OP_BRANCH, 8'h00, 8'h00, 8'h20, 16'h1010, 1'b1, 1'b1), "stall_branch");
    for (int i = 0; i < 3; i++) begin
      step(mk(1'b0, 1'b0, OP_LOAD, 8'hBB, 8'hAA, 8'h00, 16'h1010, 1'b1, 1'b0),
           $sformatf("stall_hold%0d", i));
    end
    step(mk(1'b0, 1'b1, OP_LOAD,   8'hBB, 8'hAA, 8'h00, 16'h1110, 1'b0, 1'b0), "stall_resume");
    step(mk(1'b0, 1'b1, OP_LOAD,   8'hBB, 8'hAA, 8'h00, 16'hAABB, 1'b0, 1'b0), "after_fixup_load");

    // Reset during FIXUP abandons the page correction
    step(mk(1'b0, 1'b1, OP_LOAD,   8'hF0, 8'h10, 8'h00, 16'h10F0, 1'b0, 1'b0), "rst_load");
    step(mk(1'b0, 1'b1, OP_BRANCH, 8'h00, 8'h00, 8'h20, 16'h1010, 1'b1, 1'b1), "rst_branch");
    step(mk(1'b1, 1'b1, OP_HOLD,   8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0), "rst_in_fixup");
    step(mk(1'b0, 1'b1, OP_HOLD,   8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0), "rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pc_unit
`default_nettype wire
